// File: rtl/weight_ram_loader_pkg.sv
// Shared definitions for the weight RAM write-side loader: FSM state
// encoding and the floor-log2 helper also used by the weight RAM to size
// its address bus.
package weight_ram_loader_pkg;

  // Fixed 2-bit state codes, kept as named constants so that other blocks
  // (e.g. debug taps) can decode the state without the enum type.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

  // floor(log2(value)); returns 0 for value <= 1.
  function automatic int flog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value;
    while (rem > 32'sd1) begin
      rem    = rem >>> 32'sd1;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/weight_ram_loader_if.sv
// Word stream plus RAM write port of the weight loader.
// slave  : the loader (consumes words, drives the RAM write port)
// master : the environment (word source and weight RAM)
interface weight_ram_loader_if #(
  parameter int NROW     = 16,
  parameter int NCOL     = 16,
  parameter int BITWIDTH = 18
) ();
  import weight_ram_loader_pkg::*;

  localparam int ADDR_BITWIDTH = flog2(NCOL);

  logic [BITWIDTH-1:0]      wordIn;
  logic                     wordValid;
  logic                     wordReady;
  logic [ADDR_BITWIDTH-1:0] addressIn;
  logic [BITWIDTH*NROW-1:0] rowIn;
  logic                     writeEn;

  modport slave (
    input  wordIn,
    input  wordValid,
    output wordReady,
    output addressIn,
    output rowIn,
    output writeEn
  );

  modport master (
    output wordIn,
    output wordValid,
    input  wordReady,
    input  addressIn,
    input  rowIn,
    input  writeEn
  );

endinterface

// File: rtl/weight_ram_loader_row_packer.sv
// Row assembly for the weight loader: a word counter and a row register
// into which each accepted word is inserted at its slot. The row is not
// cleared between rows; every slot is rewritten before the row is used.
module weight_row_packer
  import weight_ram_loader_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int BITWIDTH = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [BITWIDTH-1:0]      word,
  output logic [BITWIDTH*NROW-1:0] row,
  output logic                     full
);

  localparam int              CNT_W     = flog2(NROW) + 32'sd1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NROW - 32'sd1);

  logic [CNT_W-1:0]         count_r;
  logic [BITWIDTH*NROW-1:0] row_r;

  // Word counter: cleared at the start of every row, advanced per accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Row register: store the accepted word verbatim in slot count_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r <= '0;
    end else if (load) begin
      row_r[int'(count_r)*BITWIDTH +: BITWIDTH] <= word;
    end else begin
      row_r <= row_r;
    end
  end

  assign row = row_r;
  // High while the next accepted word lands in the last slot of the row.
  assign full = (count_r == LAST_SLOT);

endmodule

// File: rtl/weight_ram_loader.sv
// Write-side sequencer for the weight RAM. Packs NROW incoming words into
// one row, writes it to the next column address for one cycle and repeats
// for all NCOL columns, then pulses done. All outputs are registered so
// the RAM (capturing on negedge) sees them stable half a cycle early.
module weight_ram_loader
  import weight_ram_loader_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int NCOL     = 16,
  parameter int BITWIDTH = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  weight_ram_loader_if.slave        bus,
  output logic                      busy,
  output logic                      done
);

  localparam int                       ADDR_BITWIDTH = flog2(NCOL);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL      = ADDR_BITWIDTH'(NCOL - 32'sd1);

  state_t                   state_r;
  state_t                   state_next;
  logic [ADDR_BITWIDTH-1:0] col_r;
  logic                     word_ready_r;
  logic                     write_en_r;
  logic                     busy_r;
  logic                     done_r;

  logic                     handshake_s;
  logic                     pk_load_s;
  logic                     pk_clear_s;
  logic                     pk_full_s;
  logic [BITWIDTH*NROW-1:0] pk_row_s;
  logic                     col_clear_s;
  logic                     col_inc_s;

  // wordReady is registered and high only in FILL, so it doubles as the
  // "in FILL" qualifier for the handshake.
  assign handshake_s = bus.wordValid && word_ready_r;

  weight_row_packer #(
    .NROW     (NROW),
    .BITWIDTH (BITWIDTH)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (pk_clear_s),
    .load  (pk_load_s),
    .word  (bus.wordIn),
    .row   (pk_row_s),
    .full  (pk_full_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic and counter control strobes.
  always_comb begin
    state_next  = state_r;
    pk_load_s   = 1'b0;
    pk_clear_s  = 1'b0;
    col_clear_s = 1'b0;
    col_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next  = FILL;
          pk_clear_s  = 1'b1;
          col_clear_s = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        pk_load_s = handshake_s;
        if (handshake_s && pk_full_s) begin
          state_next = WRITE;
        end else begin
          state_next = FILL;
        end
      end
      WRITE: begin
        if (col_r == LAST_COL) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
          col_inc_s  = 1'b1;
          pk_clear_s = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Column counter: doubles as the registered RAM address; it is never
  // advanced past the last column, so it holds through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r <= '0;
    end else if (col_clear_s) begin
      col_r <= '0;
    end else if (col_inc_s) begin
      col_r <= col_r + ADDR_BITWIDTH'(1'b1);
    end else begin
      col_r <= col_r;
    end
  end

  // Registered status/strobe outputs decoded from the state being entered,
  // so each is valid for exactly the cycles the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_ready_r <= 1'b0;
      write_en_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      word_ready_r <= (state_next == FILL);
      write_en_r   <= (state_next == WRITE);
      busy_r       <= (state_next != IDLE);
      done_r       <= (state_next == DONE);
    end
  end

  assign bus.wordReady = word_ready_r;
  assign bus.writeEn   = write_en_r;
  assign bus.addressIn = col_r;
  assign bus.rowIn     = pk_row_s;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Scoreboard bench for weight_ram_loader. The driver records every word the
// loader accepts; each completed group of NROW words becomes one expected
// RAM write (address = row index in the load). A negedge monitor pops and
// compares every writeEn and checks done/busy/overlap rules each cycle.
module tb_weight_ram_loader;
  import weight_ram_loader_pkg::*;

  localparam int NROW = 16;
  localparam int NCOL = 16;
  localparam int BW   = 18;
  localparam int AW   = flog2(NCOL);
  localparam int RW   = BW * NROW;

  typedef struct {
    int            addr;
    logic [RW-1:0] row;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  weight_ram_loader_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus ();

  weight_ram_loader #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  int  cyc         = 0;
  bit  spacing_on  = 1'b0;
  int  ready_cyc   = 0;
  int  wr_in_load  = 0;
  int  last_wr_cyc = 0;
  bit  prev_last_wr = 1'b0;
  bit  prev_done    = 1'b0;
  wr_t mon_e;
  int  mon_have;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Cycle counter used for write latency/spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on every write plus per-cycle protocol rules.
  always @(negedge clk) begin
    chk_int("we_ready_overlap", int'(bus.writeEn & bus.wordReady), 0);
    chk_int("done_pulse", int'(done), int'(prev_last_wr));
    if (prev_done) chk_int("busy_after_done", int'(busy), 0);
    if (bus.writeEn === 1'b1) begin
      mon_have = exp_q.size();
      chk_int("write_expected", int'(mon_have != 0), 1);
      if (mon_have != 0) begin
        mon_e = exp_q.pop_front();
        chk_int("write_addr", int'(bus.addressIn), mon_e.addr);
        chk_row("write_row", bus.rowIn, mon_e.row);
      end
      if (spacing_on) begin
        if (wr_in_load == 0) chk_int("first_write_latency", cyc - ready_cyc, NROW);
        else                 chk_int("write_spacing", cyc - last_wr_cyc, NROW + 1);
      end
      last_wr_cyc = cyc;
      wr_in_load  = wr_in_load + 1;
    end
    prev_last_wr = (bus.writeEn === 1'b1) && (bus.addressIn == AW'(NCOL - 1));
    prev_done    = (done === 1'b1);
  end

  task automatic chk_outputs_zero(input string tag);
    chk_int({tag, "_wordReady"}, int'(bus.wordReady), 0);
    chk_int({tag, "_writeEn"}, int'(bus.writeEn), 0);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
    chk_int({tag, "_addressIn"}, int'(bus.addressIn), 0);
    chk_row({tag, "_rowIn"}, bus.rowIn, '0);
  endtask

  // One full-matrix load. Called at #1 after an edge; returns at #1 after
  // the edge that enters IDLE (or right after an abort reset).
  task automatic do_load(input int gap_pct, input bit pattern, input bit skip_start,
                         input bit poke, input int abort_row, input bit hold_start);
    int            row;
    int            k;
    int            guard;
    bit            seen;
    logic [RW-1:0] r;
    row = 0; k = 0; guard = 0; seen = 1'b0; r = '0;
    wr_in_load = 0;
    if (!skip_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    ready_cyc = cyc;
    chk_int("ready_after_start", int'(bus.wordReady), 1);
    while (row < NCOL && guard < 4000) begin
      bus.wordValid = (int'($urandom_range(99)) >= gap_pct);
      bus.wordIn    = pattern ? BW'(row * NROW + k) : BW'($urandom);
      start         = (poke && row == 3 && k == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus.wordValid && bus.wordReady) begin
        r[k*BW +: BW] = bus.wordIn;
        k++;
        if (k == NROW) begin
          exp_q.push_back('{row, r});
          k = 0;
          row++;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (row == abort_row && k == 8) begin
        bus.wordValid = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_outputs_zero("abort");
        chk_int("abort_queue_empty", exp_q.size(), 0);
        return;
      end
    end
    chk_int("rows_loaded", row, NCOL);
    bus.wordValid = 1'b0;
    start = hold_start;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk_int("done_seen", int'(seen), 1);
    chk_int("write_count", wr_in_load, NCOL);
    chk_int("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.wordValid = 1'b0;
    bus.wordIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Full load, wordValid held high, word = col*16+k, timing checked.
    spacing_on = 1'b1;
    do_load(0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    spacing_on = 1'b0;

    // 50% valid gaps, same pattern, then random word values.
    do_load(50, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    do_load(50, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // start pulsed mid-row 3: must be ignored.
    do_load(30, 1'b1, 1'b0, 1'b1, -1, 1'b0);

    // Reset after 8 words of row 2, then a fresh load from address 0.
    do_load(0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_load(20, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // Stall: start then wordValid low for 100 cycles.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk_int("stall_wordReady", int'(bus.wordReady), 1);
      chk_int("stall_busy", int'(busy), 1);
      chk_int("stall_writeEn", int'(bus.writeEn), 0);
      chk_int("stall_done", int'(done), 0);
    end
    @(posedge clk); #1;
    do_load(0, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // Back-to-back: start held through DONE; second load starts at address 0.
    do_load(0, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    chk_int("b2b_idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    do_load(10, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_ram_loader.md
# weight_ram_loader

Write-side sequencer for the weight RAM. Accepts weight words one at a time over a valid/ready stream and packs NROW words into one BITWIDTH·NROW-bit row. It then issues a single-cycle row write to the RAM write port (address, row data, write enable) and walks columns 0..NCOL-1. It sits between the host/training weight source and the weight RAM, and signals completion once the whole matrix is loaded.

## Interface
- NROW, 16, words per RAM row (row width = BITWIDTH·NROW)
- NCOL, 16, rows (addresses) in the RAM
- BITWIDTH, 18, bits per weight word
- ADDR_BITWIDTH, floor(log2(NCOL)), derived; not overridden
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a full-matrix load; sampled only in IDLE
- wordIn  in  BITWIDTH  weight word
- wordValid  in  1  wordIn valid
- wordReady  out  1  loader accepts wordIn this cycle
- addressIn  out  ADDR_BITWIDTH  RAM write address
- rowIn  out  BITWIDTH·NROW  RAM write data
- writeEn  out  1  RAM write strobe, one cycle per row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last row write

## Operation
- Reset: state=IDLE. wordReady, writeEn, busy, done, addressIn, rowIn, word counter and column counter all 0.
- IDLE: wordReady=0. start=1 → FILL; column counter cleared, word counter cleared.
- FILL: wordReady=1, busy=1.
  - A handshake occurs when wordValid&&wordReady.
  - On a handshake, word k (k = word counter) is stored at rowIn bits [k·BITWIDTH +: BITWIDTH], and the counter increments.
  - A handshake with k=NROW-1 → WRITE.
  - wordValid=0 stalls the loader indefinitely with no timeout.
- WRITE: wordReady=0, writeEn=1 for exactly one cycle, addressIn = column counter, rowIn = the assembled row.
  - If column = NCOL-1 → DONE.
  - Otherwise column+1, word counter=0 → FILL.
- DONE: done=1 for one cycle, busy=1 → IDLE. addressIn and rowIn hold their last values.
- Row buffer: not cleared between rows. Every slot is overwritten before each write, so stale data is never written.
- start outside IDLE is ignored, with no restart.
- Reset mid-load: abort immediately. The partial row is discarded, no writeEn is issued, and all outputs return to their reset values the next cycle. Already-written rows stay in the RAM.
- The column counter never wraps during a load. The load terminates at NCOL-1.
- Words are stored exactly as received, with no arithmetic.

## Timing
- All outputs are registered off posedge.
- The RAM captures on negedge, so writeEn/addressIn/rowIn are stable half a cycle before capture.
- start high at edge t → wordReady high after edge t (cycle t+1).
- The last word of a row accepted at edge t → writeEn high during cycle t+1 → wordReady high again in cycle t+2.
- Minimum load time with wordValid held high: NCOL·(NROW+1) cycles from the first wordReady to the last writeEn, then done in the following cycle.
- writeEn and wordReady are never high in the same cycle.

## Structure
- Shared package:
  - state encoding (IDLE, FILL, WRITE, DONE as 2-bit localparams)
  - log2 constant function, shared with the RAM for ADDR_BITWIDTH
- Single module. An optional sub-module, weight_row_packer, holds the word counter and row shift/insert register, with inputs load/clear and output full.
- Word counter width: floor(log2(NROW))+1. Column counter width: ADDR_BITWIDTH.

## Test plan
- Full load with defaults, wordValid always 1, word value = col·16+k:
  - expect 16 writeEn pulses at addresses 0..15, each 17 cycles apart
  - row c slot k = c·16+k
  - done exactly 1 cycle after the 16th write, then busy=0
- Random wordValid gaps (50% duty): same RAM contents as the full-load test; writeEn never coincides with wordReady; no word is lost or duplicated.
- start pulsed again in FILL after 5 words of row 3: ignored, load completes normally with 16 writes.
- reset asserted after 8 words of row 2: next cycle all outputs 0, state IDLE, no write to address 2. A new start then reloads from address 0.
- start with wordValid=0 for 100 cycles: wordReady=1, busy=1, no writeEn, done=0 throughout.
- Back-to-back loads: start held high through DONE → the second load begins from IDLE with address 0, and the first load's done pulse is exactly one cycle wide.
